// File: rtl/vend_ctrl_multi_if.sv
// ---------------------------------------------------------------------------
// vend_ctrl_multi_if
// Bundles the board-side inputs and the indicator/actuator outputs of the
// vending controller core.
//   master : testbench / board glue (drives coin_valid, coin_sel, buy, sel,
//            cancel; observes credit, dispense, deny, coin_reject,
//            change_valid, change_coin, busy)
//   slave  : vend_ctrl_multi core
// ---------------------------------------------------------------------------
interface vend_ctrl_multi_if #(
  parameter int N_ITEMS  = 5,
  parameter int CREDIT_W = 10
);
  localparam int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  logic                coin_valid;
  logic [1:0]          coin_sel;
  logic                buy;
  logic [SEL_W-1:0]    sel;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic [N_ITEMS-1:0]  dispense;
  logic                deny;
  logic                coin_reject;
  logic                change_valid;
  logic [1:0]          change_coin;
  logic                busy;

  modport master (
    output coin_valid, coin_sel, buy, sel, cancel,
    input  credit, dispense, deny, coin_reject, change_valid, change_coin, busy
  );

  modport slave (
    input  coin_valid, coin_sel, buy, sel, cancel,
    output credit, dispense, deny, coin_reject, change_valid, change_coin, busy
  );
endinterface

// File: rtl/vend_ctrl_multi.sv
// ---------------------------------------------------------------------------
// vend_ctrl_multi
// Vending-machine controller core: accumulates coin credit up to a ceiling,
// vends one of N_ITEMS products from a packed price table and pays change as
// paced greedy coin pulses.
//   CLOCK_50 : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : vend_ctrl_multi_if.slave
//              in : coin_valid, coin_sel (0=10p 1=20p 2=50p 3=100p), buy,
//                   sel, cancel
//              out: credit, dispense (one-hot), deny, coin_reject,
//                   change_valid, change_coin, busy
// All outputs are registered.
// ---------------------------------------------------------------------------
module vend_ctrl_multi #(
  parameter int                          N_ITEMS         = 5,
  parameter int                          CREDIT_W        = 10,
  parameter int                          MAX_CREDIT      = 500,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_TABLE     =
    {10'd150, 10'd120, 10'd100, 10'd80, 10'd50},
  parameter int                          DISPENSE_CYCLES = 4,
  parameter int                          CHANGE_GAP      = 2,
  parameter int                          AUTO_CHANGE     = 0
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  vend_ctrl_multi_if.slave   bus
);

  localparam int SEL_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  // One counter serves both the dispense hold and the change gap.
  localparam int CNT_MAX = (DISPENSE_CYCLES > CHANGE_GAP) ? DISPENSE_CYCLES : CHANGE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]    DISP_LOAD = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LOAD  = CNT_W'(CHANGE_GAP - 1);
  localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [N_ITEMS-1:0]  ONE_HOT0  = N_ITEMS'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VEND   = 2'd1,
    S_CHANGE = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_ITEMS-1:0]  dispense_q, dispense_d;
  logic                deny_q, deny_d;
  logic                coin_reject_q, coin_reject_d;
  logic                change_valid_q, change_valid_d;
  logic [1:0]          change_coin_q, change_coin_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W:0]   sum_s;
  logic [CREDIT_W-1:0] price_s;
  logic                sel_ok_s;
  logic [1:0]          chg_code_s;
  logic [CREDIT_W:0]   chg_val_s;
  logic [CREDIT_W-1:0] credit_left_s;

  function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
    logic [CREDIT_W:0] v;
    case (code)
      2'd0:    v = (CREDIT_W + 1)'(32'd10);
      2'd1:    v = (CREDIT_W + 1)'(32'd20);
      2'd2:    v = (CREDIT_W + 1)'(32'd50);
      2'd3:    v = (CREDIT_W + 1)'(32'd100);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Greedy payout: largest denomination not exceeding the remaining credit.
  function automatic logic [1:0] largest_coin(input logic [CREDIT_W-1:0] cr);
    logic [1:0] c;
    if (cr >= CREDIT_W'(32'd100))     c = 2'd3;
    else if (cr >= CREDIT_W'(32'd50)) c = 2'd2;
    else if (cr >= CREDIT_W'(32'd20)) c = 2'd1;
    else                              c = 2'd0;
    return c;
  endfunction

  // Out-of-range selections return 0; the caller denies them via sel_ok_s.
  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] s);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (32'(s) == 32'(i)) p = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
    end
    return p;
  endfunction

  // Arithmetic helpers shared by the next-state logic.
  always_comb begin
    sum_s         = {1'b0, credit_q} + coin_value(bus.coin_sel);
    price_s       = price_of(bus.sel);
    sel_ok_s      = (32'(bus.sel) < 32'(N_ITEMS));
    chg_code_s    = largest_coin(credit_q);
    chg_val_s     = coin_value(chg_code_s);
    credit_left_s = credit_q - chg_val_s[CREDIT_W-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    cnt_d          = cnt_q;
    dispense_d     = dispense_q;
    deny_d         = 1'b0;
    coin_reject_d  = 1'b0;
    change_valid_d = 1'b0;
    change_coin_d  = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.cancel) begin
          coin_reject_d = bus.coin_valid;
          if (credit_q != '0) state_d = S_CHANGE;
          else                state_d = S_IDLE;
        end else if (bus.buy) begin
          coin_reject_d = bus.coin_valid;
          if (!sel_ok_s || (credit_q < price_s)) begin
            deny_d = 1'b1;
          end else begin
            credit_d   = credit_q - price_s;
            dispense_d = ONE_HOT0 << bus.sel;
            cnt_d      = DISP_LOAD;
            state_d    = S_VEND;
          end
        end else if (bus.coin_valid) begin
          // Add is one bit wider than credit so the ceiling test sees overflow.
          if (sum_s <= MAX_C) credit_d      = sum_s[CREDIT_W-1:0];
          else                coin_reject_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VEND: begin
        coin_reject_d = bus.coin_valid;
        deny_d        = bus.buy;
        if (cnt_q == '0) begin
          dispense_d = '0;
          if ((AUTO_CHANGE != 0) && (credit_q != '0)) state_d = S_CHANGE;
          else                                         state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CHANGE: begin
        coin_reject_d  = bus.coin_valid;
        deny_d         = bus.buy;
        change_valid_d = 1'b1;
        change_coin_d  = chg_code_s;
        credit_d       = credit_left_s;
        if (credit_left_s != '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        coin_reject_d = bus.coin_valid;
        deny_d        = bus.buy;
        if (cnt_q == '0) state_d = S_CHANGE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d    = S_IDLE;
        credit_d   = '0;
        dispense_d = '0;
        cnt_d      = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset discards any credit in flight.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      cnt_q          <= '0;
      dispense_q     <= '0;
      deny_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      cnt_q          <= cnt_d;
      dispense_q     <= dispense_d;
      deny_q         <= deny_d;
      coin_reject_q  <= coin_reject_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.dispense     = dispense_q;
  assign bus.deny         = deny_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_coin  = change_coin_q;
  assign bus.busy         = busy_q;

endmodule
